// File: rtl/char_plotter.sv
// Glyph plotter: scans a GLYPH_W x GLYPH_H box in row-major order, asks an
// external combinational glyph LUT for each pixel and emits VGA plot strobes.
module char_plotter #(
    parameter int          GLYPH_W   = 10,
    parameter int          GLYPH_H   = 10,
    parameter bit          DRAW_BG   = 1'b0,
    parameter logic [5:0]  BG_COLOUR = 6'b000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] char_x,
    input  logic [7:0] char_y,
    input  logic       pause,
    input  logic [5:0] glyph_colour,
    input  logic       glyph_enable,
    output logic [7:0] flush_x,
    output logic [7:0] flush_y,
    output logic       plot,
    output logic [7:0] plot_x,
    output logic [7:0] plot_y,
    output logic [5:0] plot_colour,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SCAN   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [7:0] COL_LAST = 8'(GLYPH_W - 1);
    localparam logic [7:0] ROW_LAST = 8'(GLYPH_H - 1);

    logic [1:0] state_r;
    logic [7:0] origin_x_r;
    logic [7:0] off_x_r;
    logic [7:0] off_y_r;
    logic [7:0] flush_x_r;
    logic [7:0] flush_y_r;
    logic       plot_r;
    logic [7:0] plot_x_r;
    logic [7:0] plot_y_r;
    logic [5:0] plot_colour_r;
    logic       busy_r;
    logic       done_r;

    logic       hit_s;
    logic [5:0] pix_colour_s;
    logic       last_col_s;
    logic       last_row_s;

    // Per-pixel decision for the coordinate currently presented to the LUT.
    always_comb begin
        hit_s        = glyph_enable | DRAW_BG;
        pix_colour_s = BG_COLOUR;
        if (glyph_enable) begin
            pix_colour_s = glyph_colour;
        end else begin
            pix_colour_s = BG_COLOUR;
        end
        last_col_s = (off_x_r == COL_LAST);
        last_row_s = (off_y_r == ROW_LAST);
    end

    // Draw sequencer: accept, scan with pause support, completion pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= IDLE;
            origin_x_r    <= 8'd0;
            off_x_r       <= 8'd0;
            off_y_r       <= 8'd0;
            flush_x_r     <= 8'd0;
            flush_y_r     <= 8'd0;
            plot_r        <= 1'b0;
            plot_x_r      <= 8'd0;
            plot_y_r      <= 8'd0;
            plot_colour_r <= 6'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    plot_r <= 1'b0;
                    done_r <= 1'b0;
                    if (start) begin
                        origin_x_r <= char_x;
                        flush_x_r  <= char_x;
                        flush_y_r  <= char_y;
                        off_x_r    <= 8'd0;
                        off_y_r    <= 8'd0;
                        busy_r     <= 1'b1;
                        state_r    <= SCAN;
                    end
                end
                SCAN: begin
                    if (pause) begin
                        plot_r <= 1'b0;
                    end else begin
                        plot_r <= hit_s;
                        // Position/colour registers keep their last value on a miss.
                        if (hit_s) begin
                            plot_x_r      <= flush_x_r;
                            plot_y_r      <= flush_y_r;
                            plot_colour_r <= pix_colour_s;
                        end
                        if (last_col_s) begin
                            off_x_r   <= 8'd0;
                            flush_x_r <= origin_x_r;
                            if (last_row_s) begin
                                state_r <= FINISH;
                            end else begin
                                off_y_r   <= off_y_r + 8'd1;
                                flush_y_r <= flush_y_r + 8'd1;
                            end
                        end else begin
                            off_x_r   <= off_x_r + 8'd1;
                            flush_x_r <= flush_x_r + 8'd1;
                        end
                    end
                end
                FINISH: begin
                    plot_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    plot_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign flush_x     = flush_x_r;
    assign flush_y     = flush_y_r;
    assign plot        = plot_r;
    assign plot_x      = plot_x_r;
    assign plot_y      = plot_y_r;
    assign plot_colour = plot_colour_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: doc/char_plotter.md
CHAR_PLOTTER -- requirements
Module: char_plotter

Interface
REQ-001 Parameter GLYPH_W, default 10, glyph box width in pixels.
REQ-002 Parameter GLYPH_H, default 10, glyph box height in pixels.
REQ-003 Parameter DRAW_BG, default 0; 1 = also plot background pixels.
REQ-004 Parameter BG_COLOUR, default 6'b000000, colour used for background pixels.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 resetn  in  1  asynchronous active-low reset.
REQ-007 start  in  1  request to draw one glyph, sampled in IDLE only.
REQ-008 char_x  in  8  glyph origin x, latched on accepted start.
REQ-009 char_y  in  8  glyph origin y, latched on accepted start.
REQ-010 pause  in  1  freezes scanning while high.
REQ-011 glyph_colour  in  6  colour returned by the glyph LUT for the presented flush coordinate.
REQ-012 glyph_enable  in  1  LUT hit flag for the presented flush coordinate.
REQ-013 flush_x  out  8  scan x coordinate presented to the glyph LUT.
REQ-014 flush_y  out  8  scan y coordinate presented to the glyph LUT.
REQ-015 plot  out  1  one-cycle pixel write strobe to the VGA adapter.
REQ-016 plot_x  out  8  pixel x for plot.
REQ-017 plot_y  out  8  pixel y for plot.
REQ-018 plot_colour  out  6  pixel colour for plot.
REQ-019 busy  out  1  high while a glyph is being drawn.
REQ-020 done  out  1  one-cycle completion pulse.

Function
REQ-021 The FSM SHALL have three states: IDLE, SCAN and FINISH.
REQ-022 IDLE with start=1 at an edge SHALL latch char_x/char_y, load flush_x=char_x and flush_y=char_y, set busy=1 and enter SCAN.
REQ-023 start in SCAN or FINISH SHALL be ignored, with no queuing.
REQ-024 The glyph LUT SHALL be treated as combinational; the block SHALL sample glyph_enable/glyph_colour in the same cycle it presents flush_x/flush_y.
REQ-025 At each SCAN edge with pause=0: plot SHALL be loaded with glyph_enable|DRAW_BG, plot_x/plot_y with the current flush coordinates, and plot_colour with glyph_colour if glyph_enable=1, otherwise BG_COLOUR.
REQ-026 At the same SCAN edge the coordinates SHALL advance in row-major order: flush_x+1; after offset GLYPH_W-1, flush_x returns to the origin x and flush_y+1.
REQ-027 At each SCAN edge with pause=1: coordinates SHALL hold and plot SHALL load 0, so every coordinate is emitted exactly once.
REQ-028 The edge that consumes offset (GLYPH_W-1, GLYPH_H-1) SHALL enter FINISH.
REQ-029 FINISH SHALL ignore pause; at its edge: plot=0, busy=0, done=1, state to IDLE.
REQ-030 done SHALL clear at the next edge, and IDLE SHALL keep plot=0.
REQ-031 Timing for an unpaused draw accepted at edge E0: coordinates are presented during the GLYPH_W*GLYPH_H cycles after E0; plots are visible after edges E1..E(W*H); done=1 and busy=0 after edge E(W*H+1).
REQ-032 Coordinate arithmetic SHALL be modulo 256, so an origin near 255 wraps to 0 without error.
REQ-033 plot_x/plot_y/plot_colour SHALL hold their last values when plot=0.

Reset
REQ-034 resetn=0 SHALL immediately force IDLE and set flush_x, flush_y, plot, plot_x, plot_y, plot_colour, busy and done to 0.
REQ-035 A reset mid-draw SHALL abort the draw, with no further plot and no done pulse.
REQ-036 After release, the first start SHALL be accepted normally.

Verification
REQ-037 'E' LUT, origin (16,20), DRAW_BG=0, start pulse -> 25 plots, first at (18,20), last at (23,29), all colour 6'h3F; done after E101.
REQ-038 Same stimulus with DRAW_BG=1 -> 100 plots in row-major order, 75 with colour 0; done after E101.
REQ-039 Origin (250,250), DRAW_BG=1 -> plot_x sequence 250..255,0..3, and the final plot is at (3,3).
REQ-040 pause high for 5 cycles mid-scan -> no duplicate or missing coordinate, and done is delayed by exactly 5 cycles.
REQ-041 start held high throughout -> a new draw begins only at the edge after done; start pulses during SCAN are ignored.
REQ-042 resetn low at cycle 40 of a draw -> all outputs 0 at once, no done pulse; a fresh start then completes a normal draw.
